// File: rtl/coloured_seq_detector.sv
// coloured_seq_detector: Mealy detector for programmable coloured-ball patterns.
// Ports: clk/rst, di_valid/di ball in, cfg_* pattern load, cnt_clr, d pulse, match_count, cfg_err.
module coloured_seq_detector #(
  parameter int COLOR_W = 1,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W = 8,
  parameter logic [SEQ_LEN*COLOR_W-1:0] DEF_PATTERN = 4'b1010,
  parameter logic DEF_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         di_valid,
  input  logic [COLOR_W-1:0]           di,
  input  logic                         cfg_load,
  input  logic [SEQ_LEN*COLOR_W-1:0]   cfg_pattern,
  input  logic [$clog2(SEQ_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         d,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err
);

  localparam int LW = $clog2(SEQ_LEN+1);
  localparam int HN = SEQ_LEN-1;

  logic [SEQ_LEN-1:0][COLOR_W-1:0] r_pattern;
  logic [HN-1:0][COLOR_W-1:0]      r_hist;
  logic [LW-1:0]                   r_len;
  logic [LW-1:0]                   r_fill;
  logic                            r_overlap;
  logic                            r_enabled;
  logic                            r_cfg_err;
  logic [CNT_W-1:0]                r_cnt;

  logic w_mis;
  logic w_fill_ok;
  logic w_len_ok;
  logic w_d;

  // Pattern symbol len-1 pairs with the incoming ball and symbol
  // len-2-i pairs with history slot i; positions past len are skipped.
  always_comb begin
    w_mis = 1'b0;
    for (int j = 0; j < SEQ_LEN; j++) begin
      if (j == int'(r_len) - 1 && di != r_pattern[j]) begin
        w_mis = 1'b1;
      end
    end
    for (int i = 0; i < HN; i++) begin
      for (int j = 0; j < SEQ_LEN; j++) begin
        if (i + j == int'(r_len) - 2 && r_hist[i] != r_pattern[j]) begin
          w_mis = 1'b1;
        end
      end
    end
  end

  assign w_fill_ok = int'(r_fill) >= int'(r_len) - 1;
  assign w_len_ok  = (cfg_len != '0) && (int'(cfg_len) <= SEQ_LEN);

  assign w_d = di_valid & ~rst & ~cfg_load & r_enabled
             & w_fill_ok & ~w_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= LW'(SEQ_LEN);
      r_overlap <= DEF_OVERLAP;
      r_enabled <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_d && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_enabled <= w_len_ok;
        r_hist    <= '0;
        r_fill    <= '0;
        if (!w_len_ok) begin
          r_cfg_err <= 1'b1;
        end
      end else if (di_valid) begin
        if (w_d && !r_overlap) begin
          // Completing ball is consumed; next match starts fresh.
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          for (int i = HN - 1; i > 0; i--) begin
            r_hist[i] <= r_hist[i-1];
          end
          r_hist[0] <= di;
          if (r_fill != LW'(HN)) begin
            r_fill <= r_fill + LW'(1);
          end
        end
      end
    end
  end

  assign d           = w_d;
  assign match_count = r_cnt;
  assign cfg_err     = r_cfg_err;

endmodule
